// File: rtl/tlu_pkg.sv
// Shared TLU protocol definitions: FSM states, trigger-mode encodings and
// the default trigger-number width used by both the DUT responder and the TLU master.
package tlu_pkg;

  localparam int TRIG_ID_BITS_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT_LOW,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_RELEASE
  } tlu_state_e;

  typedef enum logic [1:0] {
    MODE_SIMPLE = 2'd0,
    MODE_HS     = 2'd1,
    MODE_DATA   = 2'd2,
    MODE_RSVD   = 2'd3
  } tlu_mode_e;

  // The reserved encoding falls back to the simple protocol.
  function automatic tlu_mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_SIMPLE : tlu_mode_e'(m);
  endfunction

endpackage

// File: rtl/tlu_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous TLU line.
module tlu_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/tlu_dut_responder.sv
// DUT-side TLU responder: acknowledges triggers with BUSY and, in data-handshake
// mode, clocks the trigger number out of the TLU over the TRIGGER line.
module tlu_dut_responder
  import tlu_pkg::*;
#(
  parameter int TRIG_ID_BITS = TRIG_ID_BITS_DEF,
  parameter int CLK_DIV      = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
  input  logic                    ENABLE,
  input  logic [1:0]              MODE,
  input  logic                    TLU_TRIGGER,
  output logic                    TLU_BUSY,
  output logic                    TLU_CLOCK,
  input  logic                    VETO,
  output logic                    TRIG_VALID,
  output logic [TRIG_ID_BITS-1:0] TRIG_ID,
  output logic [31:0]             TRIG_COUNT,
  output logic                    TIMEOUT_ERR
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam int BC_W = $clog2(TRIG_ID_BITS + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(TRIG_ID_BITS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  tlu_state_e              r_state;
  tlu_mode_e               r_mode;
  logic                    r_trig_prev;
  logic [PH_W-1:0]         r_phase;
  logic [BC_W-1:0]         r_bitcnt;
  logic [TO_W-1:0]         r_to;
  logic [TRIG_ID_BITS-1:0] r_shift;
  logic                    r_busy, r_clk, r_valid, r_err;
  logic [TRIG_ID_BITS-1:0] r_id;
  logic [31:0]             r_count;

  logic w_trig_s, w_rise;
  tlu_mode_e w_mode_in;

  tlu_sync_2ff u_sync (
    .i_clk   (BUS_CLK),
    .i_rst_n (BUS_RST_N),
    .i_d     (TLU_TRIGGER),
    .o_q     (w_trig_s)
  );

  assign w_rise    = w_trig_s & ~r_trig_prev;
  assign w_mode_in = norm_mode(MODE);

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_SIMPLE;
      r_trig_prev <= 1'b0;
      r_phase     <= '0;
      r_bitcnt    <= '0;
      r_to        <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_clk       <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_id        <= '0;
      r_count     <= '0;
    end else begin
      r_trig_prev <= w_trig_s;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && ENABLE) begin
            r_mode  <= w_mode_in;
            r_busy  <= 1'b1;
            r_state <= ST_ACK;
            // Simple mode reports the trigger together with the BUSY edge.
            if (w_mode_in == MODE_SIMPLE) begin
              r_valid <= 1'b1;
              r_id    <= r_count[TRIG_ID_BITS-1:0];
              r_count <= r_count + 32'd1;
            end
          end
        end
        ST_ACK: begin
          r_to    <= '0;
          r_state <= (r_mode == MODE_SIMPLE) ? ST_RELEASE : ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!w_trig_s) begin
            if (r_mode == MODE_DATA) begin
              r_clk    <= 1'b1;
              r_phase  <= '0;
              r_bitcnt <= '0;
              r_state  <= ST_SHIFT_HI;
            end else begin
              r_valid <= 1'b1;
              r_id    <= r_count[TRIG_ID_BITS-1:0];
              r_count <= r_count + 32'd1;
              r_state <= ST_RELEASE;
            end
          end else if (r_to == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_RELEASE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (r_phase == PH_LAST) begin
            r_shift  <= {r_shift[TRIG_ID_BITS-2:0], w_trig_s};
            r_bitcnt <= r_bitcnt + 1'b1;
            r_phase  <= '0;
            r_clk    <= 1'b0;
            r_state  <= ST_SHIFT_LO;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            if (r_bitcnt == BC_LAST) begin
              r_valid <= 1'b1;
              r_id    <= r_shift;
              r_count <= r_count + 32'd1;
              r_state <= ST_RELEASE;
            end else begin
              r_clk   <= 1'b1;
              r_state <= ST_SHIFT_HI;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!VETO && !w_trig_s) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign TLU_BUSY    = r_busy;
  assign TLU_CLOCK   = r_clk;
  assign TRIG_VALID  = r_valid;
  assign TRIG_ID     = r_id;
  assign TRIG_COUNT  = r_count;
  assign TIMEOUT_ERR = r_err;

endmodule
